// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: NUM_STAGES-deep valid/payload pipeline with stall, bubble and squash control.
// Latency: NUM_STAGES cycles from acceptance to out_valid when nothing holds; one entry per cycle.
// Backpressure: any hold propagates to every upstream stage in the same cycle and drops in_ready.
// Optional feature: define PIPE_PERF_CNT_EN to build the saturating perf_* event counters;
// without it the perf_* outputs are tied to zero and no counter registers exist.
module pipeline_control_unit #(
  parameter int NUM_STAGES   = 5,
  parameter int PAYLOAD_W    = 64,
  parameter int BUBBLE_STAGE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [PAYLOAD_W-1:0]            in_payload,
  output logic                            in_ready,
  input  logic [NUM_STAGES-1:0]           stall_req,
  input  logic                            hazard_bubble,
  input  logic                            kill_valid,
  input  logic [$clog2(NUM_STAGES)-1:0]   kill_stage,
  output logic [NUM_STAGES-1:0]           stage_valid,
  output logic [NUM_STAGES*PAYLOAD_W-1:0] stage_payload,
  output logic                            out_valid,
  output logic [PAYLOAD_W-1:0]            out_payload,
  output logic [31:0]                     perf_stall,
  output logic [31:0]                     perf_bubble,
  output logic [31:0]                     perf_kill,
  output logic [31:0]                     perf_retire
);

  localparam int KW = $clog2(NUM_STAGES);
  localparam logic [KW-1:0] LAST_IDX = KW'(NUM_STAGES - 1);

  // Stage state: valid is authoritative, payload of an invalid stage is don't-care.
  logic [NUM_STAGES-1:0]                r_vld;
  logic [NUM_STAGES-1:0][PAYLOAD_W-1:0] r_pay;

  logic [NUM_STAGES-1:0]                w_hold;
  logic [NUM_STAGES-1:0]                w_kill_mask;
  logic [NUM_STAGES-1:0]                w_nxt_vld;
  logic [NUM_STAGES-1:0][PAYLOAD_W-1:0] w_nxt_pay;
  logic [KW-1:0]                        w_kill_idx;
  logic                                 w_bubble_evt;

  // Hold chain: a stage holds if it or any downstream stage stalls; a hazard freezes
  // everything below BUBBLE_STAGE. Walking from the tail keeps it a single OR chain.
  always_comb begin : p_hold
    logic acc;
    acc    = 1'b0;
    w_hold = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc       = acc | stall_req[i] | (hazard_bubble & (i < BUBBLE_STAGE));
      w_hold[i] = acc;
    end
  end

  // Out-of-range kill indices squash everything upstream of the last stage.
  assign w_kill_idx = (kill_stage > LAST_IDX) ? LAST_IDX : kill_stage;

  // Squash mask: stages strictly younger than the killing stage lose their entries.
  always_comb begin : p_kill_mask
    w_kill_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_kill_mask[i] = kill_valid & (KW'(i) < w_kill_idx);
    end
  end

  // Stage 0 takes the new entry unless held; a kill drops the incoming entry.
  assign w_nxt_vld[0] = w_kill_mask[0] ? 1'b0 :
                        w_hold[0]      ? r_vld[0] :
                                         (in_valid & ~kill_valid);
  assign w_nxt_pay[0] = w_hold[0] ? r_pay[0] : in_payload;

  // Stages 1..N-1 take the upstream entry unless held. A held upstream or a squashed
  // upstream entry turns the move into a bubble. Kill wins over hold for squashed stages.
  for (genvar g = 1; g < NUM_STAGES; g++) begin : g_stage
    assign w_nxt_vld[g] = w_kill_mask[g] ? 1'b0 :
                          w_hold[g]      ? r_vld[g] :
                                           (~w_hold[g-1] & r_vld[g-1] & ~w_kill_mask[g-1]);
    assign w_nxt_pay[g] = w_hold[g] ? r_pay[g] : r_pay[g-1];
  end

  // Holds are a contiguous prefix, so at most one released-after-held boundary exists.
  assign w_bubble_evt = |(w_hold[NUM_STAGES-2:0] & ~w_hold[NUM_STAGES-1:1]);

  // Stage registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= '0;
      r_pay <= '0;
    end else begin
      r_vld <= w_nxt_vld;
      r_pay <= w_nxt_pay;
    end
  end

  assign in_ready      = rst & ~w_hold[0] & ~kill_valid;
  assign stage_valid   = r_vld;
  assign stage_payload = r_pay;
  assign out_valid     = r_vld[NUM_STAGES-1] & ~stall_req[NUM_STAGES-1];
  assign out_payload   = r_pay[NUM_STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_bubble;
  logic [31:0] r_perf_kill;
  logic [31:0] r_perf_retire;

  // Saturating event counters, one increment per qualifying cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_stall  <= '0;
      r_perf_bubble <= '0;
      r_perf_kill   <= '0;
      r_perf_retire <= '0;
    end else begin
      if ((|stall_req) && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_bubble_evt && (r_perf_bubble != 32'hFFFF_FFFF)) begin
        r_perf_bubble <= r_perf_bubble + 32'd1;
      end
      if (kill_valid && (r_perf_kill != 32'hFFFF_FFFF)) begin
        r_perf_kill <= r_perf_kill + 32'd1;
      end
      if (out_valid && (r_perf_retire != 32'hFFFF_FFFF)) begin
        r_perf_retire <= r_perf_retire + 32'd1;
      end
    end
  end

  assign perf_stall  = r_perf_stall;
  assign perf_bubble = r_perf_bubble;
  assign perf_kill   = r_perf_kill;
  assign perf_retire = r_perf_retire;
`else
  // Counters not built: outputs are constant zero.
  assign perf_stall  = 32'd0;
  assign perf_bubble = 32'd0;
  assign perf_kill   = 32'd0;
  assign perf_retire = 32'd0;
  logic w_unused;
  assign w_unused = w_bubble_evt;
`endif

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline register stages (legal 2..16).
REQ-002 SHALL have parameter PAYLOAD_W, default 64, payload bits carried per stage alongside valid.
REQ-003 SHALL have parameter BUBBLE_STAGE, default 1, index of the stage that receives a bubble on hazard_bubble (legal 1..NUM_STAGES-1).
REQ-004 SHALL have one clock and a synchronous active-low reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-low reset.
REQ-005 SHALL have in_valid  input  1  new entry offered to stage 0.
REQ-006 SHALL have in_payload  input  PAYLOAD_W  payload of the new entry.
REQ-007 SHALL have in_ready  output  1  stage 0 accepts in this cycle.
REQ-008 SHALL have stall_req  input  NUM_STAGES  per-stage hold request (bit i = stage i), e.g. cache miss.
REQ-009 SHALL have hazard_bubble  input  1  hold stages below BUBBLE_STAGE and inject a bubble at BUBBLE_STAGE.
REQ-010 SHALL have kill_valid  input  1  squash request.
REQ-011 SHALL have kill_stage  input  $clog2(NUM_STAGES)  index of the killing stage.
REQ-012 SHALL have stage_valid  output  NUM_STAGES  registered valid of each stage.
REQ-013 SHALL have stage_payload  output  NUM_STAGES*PAYLOAD_W  registered payloads, stage i at bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-014 SHALL have out_valid  output  1  last stage retires this cycle; out_payload  output  PAYLOAD_W  retiring payload.
REQ-015 SHALL have perf_stall, perf_bubble, perf_kill, perf_retire  output  32 each  event counters (see Configuration).

Function
REQ-016 SHALL compute hold h[NUM_STAGES-1]=stall_req[NUM_STAGES-1], h[i]=stall_req[i] | h[i+1], combinationally, backward propagation in one cycle.
REQ-017 SHALL additionally set h[i]=1 for all i<BUBBLE_STAGE when hazard_bubble=1.
REQ-018 Stage i with h[i]=1 SHALL keep valid and payload unchanged.
REQ-019 Stage i>0 with h[i]=0 SHALL load stage i-1 contents; if h[i-1]=1 it SHALL load valid=0 (bubble).
REQ-020 Stage 0 with h[0]=0 SHALL load in_valid/in_payload; in_ready = ~h[0] & ~kill_valid.
REQ-021 out_valid SHALL equal stage_valid[NUM_STAGES-1] & ~stall_req[NUM_STAGES-1]; out_payload = stage_payload of last stage, combinational.
REQ-022 On kill_valid with kill_stage=k: next valid of stages 0..k-1 SHALL be 0, overriding hold; stage k itself advances or holds per REQ-018/019; in_payload is dropped.
REQ-023 Kill SHALL override hazard_bubble and stall_req for stages 0..k-1; stalls at stages >=k SHALL still apply.
REQ-024 kill_stage >= NUM_STAGES SHALL be treated as NUM_STAGES-1.
REQ-025 Payload registers of invalid stages SHALL still be written (don't-care content); only valid is authoritative.
REQ-026 Latency SHALL be NUM_STAGES cycles from acceptance to out_valid with no holds; throughput one entry per cycle.

Reset
REQ-027 With rst=0 at a clk edge all stage_valid SHALL become 0, payload registers 0, counters 0; in_ready SHALL be 0 while rst=0.
REQ-028 Reset asserted mid-stall or mid-kill SHALL take priority over all other inputs that cycle.

Configuration
REQ-029 Macro PIPE_PERF_CNT_EN defined: perf_stall += 1 per cycle with any stall_req bit set; perf_bubble += 1 per bubble injected (REQ-019 or REQ-017); perf_kill += 1 per cycle kill_valid=1; perf_retire += 1 per out_valid; all saturate at 32'hFFFFFFFF.
REQ-030 Macro PIPE_PERF_CNT_EN undefined: counter registers SHALL not exist; perf_* outputs SHALL be constant 0.

Verification
REQ-031 Stream 8 entries payload 1..8, no holds -> entry 1 at out_valid on cycle 5 after acceptance, then 2..8 back-to-back.
REQ-032 stall_req=5'b01000 for 3 cycles with pipe full -> stages 0..3 frozen, stage 4 valid=0 for 3 cycles, in_ready=0, perf_stall=3.
REQ-033 hazard_bubble=1 for 1 cycle -> stage 0 held, stage 1 valid=0 next cycle, stages 2..4 advance, perf_bubble=1.
REQ-034 kill_valid=1, kill_stage=2, pipe full payloads A..E -> next cycle stages 0..2 valid=0 (0,1 squashed; stage 2 bubble), stage 3 holds old stage-2 payload, in_payload dropped.
REQ-035 kill_stage=2 with stall_req[3]=1 same cycle -> stages 0,1 cleared, stages 2..3 held, stage 4 bubble.
REQ-036 rst=0 asserted during REQ-032 stall -> all valid=0, perf_*=0 next cycle; with macro undefined perf_* remain 0 throughout.
